// File: rtl/eig_core_pipe_if.sv
// Handshake and result bundle for eig_core_pipe.
// The sigma member and its modport entries exist only when EIG_SIGMA_EN is defined.
interface eig_core_pipe_if #(
  parameter int W    = 32,
  parameter int CH_W = 2
);
  logic            in_valid;
  logic            in_ready;
  logic [W-1:0]    a0;
  logic [W-1:0]    a1;
  logic [CH_W-1:0] in_ch;
  logic            out_valid;
  logic            out_ready;
  logic [CH_W-1:0] out_ch;
  logic [2:0]      regime;
  logic [W-1:0]    kappa;
  logic [W-1:0]    inv_kappa;
  logic            div_zero;
`ifdef EIG_SIGMA_EN
  logic [W-1:0]    sigma;

  modport master (
    output in_valid, a0, a1, in_ch, out_ready,
    input  in_ready, out_valid, out_ch, regime, kappa, inv_kappa, div_zero, sigma
  );
  modport slave (
    input  in_valid, a0, a1, in_ch, out_ready,
    output in_ready, out_valid, out_ch, regime, kappa, inv_kappa, div_zero, sigma
  );
`else
  modport master (
    output in_valid, a0, a1, in_ch, out_ready,
    input  in_ready, out_valid, out_ch, regime, kappa, inv_kappa, div_zero
  );
  modport slave (
    input  in_valid, a0, a1, in_ch, out_ready,
    output in_ready, out_valid, out_ch, regime, kappa, inv_kappa, div_zero
  );
`endif
endinterface

// File: rtl/eig_core_pipe.sv
// Bit-serial eigenvalue core: classifies s^2 + beta*s + alpha and returns kappa and 1/kappa.
// Defining EIG_SIGMA_EN adds the sigma (real part) output.
module eig_core_pipe #(
  parameter int W    = 32,
  parameter int F    = 16,
  parameter int CH_W = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           ena,
  eig_core_pipe_if.slave bus
);

  localparam int DW = 2*W + 2;
  localparam int QX = 2*F + W + 1;
  localparam int CW = $clog2(W + 2*F + 2);
  localparam logic [CW-1:0] SQ_LAST  = CW'(W);
  localparam logic [CW-1:0] RC_LAST  = CW'(2*F + 1);
  localparam logic [W-1:0]  MAX_POS  = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0]  MIN_NEG  = {1'b1, {(W-1){1'b0}}};
  localparam logic [2*F:0]  NUM_INIT = (2*F+1)'(1'b1) << (2*F);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DISC  = 3'd1,
    SQRT  = 3'd2,
    RECIP = 3'd3,
    OUT   = 3'd4
  } state_t;

  state_t state_r, state_nx_s;

  logic                 in_ready_r, out_valid_r;
  logic signed [W-1:0]  a0_r, a1_r;
  logic [CH_W-1:0]      ch_r;
  logic [2:0]           regime_w_r;
  logic [2*W-1:0]       rad_r;
  logic [W-1:0]         root_r;
  logic [W+1:0]         rem_r;
  logic [W-1:0]         kappa_w_r;
  logic [W:0]           drem_r;
  logic [2*F:0]         num_r;
  logic [QX-1:0]        quo_r;
  logic [CW-1:0]        cnt_r;

  logic [2:0]           regime_r;
  logic [W-1:0]         kappa_r, inv_kappa_r;
  logic                 div_zero_r;
  logic [CH_W-1:0]      out_ch_r;

  logic signed [DW-1:0] a0_x_s, a1_x_s, sq_s, sh_s, disc_s;
  logic [2*W-1:0]       rad_s;
  logic [2:0]           regime_s;
  logic [W+1:0]         rem_t_s, trial_s;
  logic [W:0]           drem_t_s;
  logic                 kz_s, sat_s;
  logic [W-1:0]         inv_s;

  // Real part of the roots: -beta/2 with -MIN saturated to MAX before halving.
  function automatic logic [W-1:0] half_neg(input logic [W-1:0] b);
    logic [W-1:0] n;
    if (b == MIN_NEG) begin
      n = MAX_POS;
    end else begin
      n = ~b + {{(W-1){1'b0}}, 1'b1};
    end
    return {n[W-1], n[W-1:1]};
  endfunction

  // Discriminant in Q.2F and its magnitude; |disc| always fits in 2W bits.
  always_comb begin
    a0_x_s = {{(DW-W){a0_r[W-1]}}, a0_r};
    a1_x_s = {{(DW-W){a1_r[W-1]}}, a1_r};
    sq_s   = a1_x_s * a1_x_s;
    sh_s   = a0_x_s <<< (F+2);
    disc_s = sq_s - sh_s;
    if (disc_s[DW-1]) begin
      rad_s    = ~disc_s[2*W-1:0] + {{(2*W-1){1'b0}}, 1'b1};
      regime_s = 3'b001;
    end else if (disc_s == {DW{1'b0}}) begin
      rad_s    = disc_s[2*W-1:0];
      regime_s = 3'b010;
    end else begin
      rad_s    = disc_s[2*W-1:0];
      regime_s = 3'b100;
    end
  end

  // One step each of the restoring square root and the restoring divider.
  always_comb begin
    rem_t_s  = (rem_r << 2'd2) | {{W{1'b0}}, rad_r[2*W-1 -: 2]};
    trial_s  = {root_r, 2'b01};
    drem_t_s = (drem_r << 1'b1) | {{W{1'b0}}, num_r[2*F]};
    kz_s     = (kappa_w_r == {W{1'b0}});
    sat_s    = kz_s | (|quo_r[QX-1:W-1]);
    if (sat_s) begin
      inv_s = MAX_POS;
    end else begin
      inv_s = quo_r[W-1:0];
    end
  end

  // Next-state logic; every phase length is data independent.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.in_valid) state_nx_s = DISC;
        else              state_nx_s = IDLE;
      end
      DISC: state_nx_s = SQRT;
      SQRT: begin
        if (cnt_r == SQ_LAST) state_nx_s = RECIP;
        else                  state_nx_s = SQRT;
      end
      RECIP: begin
        if (cnt_r == RC_LAST) state_nx_s = OUT;
        else                  state_nx_s = RECIP;
      end
      OUT: begin
        if (bus.out_ready) state_nx_s = IDLE;
        else               state_nx_s = OUT;
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // State register; ena=0 freezes the sequence.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else if (ena) begin
      state_r <= state_nx_s;
    end else begin
      state_r <= state_r;
    end
  end

  // Datapath, handshake flags and result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      a0_r        <= {W{1'b0}};
      a1_r        <= {W{1'b0}};
      ch_r        <= {CH_W{1'b0}};
      regime_w_r  <= 3'b000;
      rad_r       <= {(2*W){1'b0}};
      root_r      <= {W{1'b0}};
      rem_r       <= {(W+2){1'b0}};
      kappa_w_r   <= {W{1'b0}};
      drem_r      <= {(W+1){1'b0}};
      num_r       <= {(2*F+1){1'b0}};
      quo_r       <= {QX{1'b0}};
      cnt_r       <= {CW{1'b0}};
      regime_r    <= 3'b000;
      kappa_r     <= {W{1'b0}};
      inv_kappa_r <= {W{1'b0}};
      div_zero_r  <= 1'b0;
      out_ch_r    <= {CH_W{1'b0}};
    end else if (ena) begin
      in_ready_r  <= (state_nx_s == IDLE);
      out_valid_r <= (state_nx_s == OUT);
      case (state_r)
        IDLE: begin
          if (bus.in_valid) begin
            a0_r <= $signed(bus.a0);
            a1_r <= $signed(bus.a1);
            ch_r <= bus.in_ch;
          end
        end
        DISC: begin
          regime_w_r <= regime_s;
          rad_r      <= rad_s;
          root_r     <= {W{1'b0}};
          rem_r      <= {(W+2){1'b0}};
          cnt_r      <= {CW{1'b0}};
        end
        SQRT: begin
          if (cnt_r == SQ_LAST) begin
            kappa_w_r <= root_r >> 1'b1;
            drem_r    <= {(W+1){1'b0}};
            num_r     <= NUM_INIT;
            quo_r     <= {QX{1'b0}};
            cnt_r     <= {CW{1'b0}};
          end else begin
            rad_r <= rad_r << 2'd2;
            if (rem_t_s >= trial_s) begin
              rem_r  <= rem_t_s - trial_s;
              root_r <= {root_r[W-2:0], 1'b1};
            end else begin
              rem_r  <= rem_t_s;
              root_r <= {root_r[W-2:0], 1'b0};
            end
            cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
          end
        end
        RECIP: begin
          if (cnt_r == RC_LAST) begin
            regime_r    <= regime_w_r;
            kappa_r     <= kappa_w_r;
            inv_kappa_r <= inv_s;
            div_zero_r  <= kz_s;
            out_ch_r    <= ch_r;
          end else begin
            // A zero divisor leaves the divider idle; the counter still runs.
            if (!kz_s) begin
              num_r <= num_r << 1'b1;
              if (drem_t_s >= {1'b0, kappa_w_r}) begin
                drem_r <= drem_t_s - {1'b0, kappa_w_r};
                quo_r  <= (quo_r << 1'b1) | {{(QX-1){1'b0}}, 1'b1};
              end else begin
                drem_r <= drem_t_s;
                quo_r  <= quo_r << 1'b1;
              end
            end
            cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
          end
        end
        OUT: begin
          cnt_r <= {CW{1'b0}};
        end
        default: begin
          cnt_r <= {CW{1'b0}};
        end
      endcase
    end
  end

`ifdef EIG_SIGMA_EN
  logic [W-1:0] sigma_w_r, sigma_r;

  // sigma is computed in DISC and published with the rest of the result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sigma_w_r <= {W{1'b0}};
      sigma_r   <= {W{1'b0}};
    end else if (ena) begin
      if (state_r == DISC) begin
        sigma_w_r <= half_neg(a1_r);
      end
      if (state_r == RECIP && cnt_r == RC_LAST) begin
        sigma_r <= sigma_w_r;
      end
    end
  end

  assign bus.sigma = sigma_r;
`endif

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_ch    = out_ch_r;
  assign bus.regime    = regime_r;
  assign bus.kappa     = kappa_r;
  assign bus.inv_kappa = inv_kappa_r;
  assign bus.div_zero  = div_zero_r;

endmodule

// File: tb/tb_eig_core_pipe.sv
// Directed bench for eig_core_pipe: latency, regimes, back-pressure, reset abort and ena freeze.
// Checks sigma as well when EIG_SIGMA_EN is defined.
module tb_eig_core_pipe;
  localparam int W    = 32;
  localparam int F    = 16;
  localparam int CH_W = 2;
  localparam int LAT  = W + 2*F + 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic ena   = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   n;

  eig_core_pipe_if #(.W(W), .CH_W(CH_W)) bus ();

  eig_core_pipe #(.W(W), .F(F), .CH_W(CH_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] a0, input logic [W-1:0] a1, input logic [CH_W-1:0] ch);
    bus.a0       = a0;
    bus.a1       = a1;
    bus.in_ch    = ch;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
  endtask

  // Counts edges after the accept edge until out_valid; optionally drops ena for a window.
  task automatic wait_result(input int fr_at, input int fr_len, output int edges);
    edges = 0;
    while (bus.out_valid !== 1'b1 && edges < 300) begin
      tick();
      edges++;
      if (fr_at > 0 && edges == fr_at) ena = 1'b0;
      if (fr_at > 0 && edges == fr_at + fr_len) ena = 1'b1;
    end
  endtask

  task automatic check_result(input string tag, input logic [2:0] reg_e, input logic [W-1:0] k_e,
                              input logic [W-1:0] ik_e, input logic dz_e, input logic [CH_W-1:0] ch_e);
    check({tag, ".out_valid"}, bus.out_valid, 1'b1);
    check({tag, ".regime"},    bus.regime,    reg_e);
    check({tag, ".kappa"},     bus.kappa,     k_e);
    check({tag, ".inv_kappa"}, bus.inv_kappa, ik_e);
    check({tag, ".div_zero"},  bus.div_zero,  dz_e);
    check({tag, ".out_ch"},    bus.out_ch,    ch_e);
  endtask

  task automatic check_reset(input string tag);
    check({tag, ".in_ready"},  bus.in_ready,  1'b1);
    check({tag, ".out_valid"}, bus.out_valid, 1'b0);
    check({tag, ".regime"},    bus.regime,    3'b000);
    check({tag, ".kappa"},     bus.kappa,     32'h0);
    check({tag, ".inv_kappa"}, bus.inv_kappa, 32'h0);
    check({tag, ".div_zero"},  bus.div_zero,  1'b0);
    check({tag, ".out_ch"},    bus.out_ch,    2'd0);
  endtask

  task automatic accept_result(input string tag);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check({tag, ".drop_valid"}, bus.out_valid, 1'b0);
    check({tag, ".ready_back"}, bus.in_ready,  1'b1);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a0        = 32'h0;
    bus.a1        = 32'h0;
    bus.in_ch     = 2'd0;

    tick();
    tick();
    check_reset("rst");
    rst_n = 1'b1;
    tick();

    // Case 1: alpha=1.0, beta=0 -> underdamped, kappa=1.0, 1/kappa=1.0.
    send(32'h0001_0000, 32'h0, 2'd1);
    check("c1.in_ready_low", bus.in_ready, 1'b0);
    wait_result(0, 0, n);
    check("c1.latency", n, LAT);
    check_result("c1", 3'b001, 32'h0001_0000, 32'h0001_0000, 1'b0, 2'd1);
`ifdef EIG_SIGMA_EN
    check("c1.sigma", bus.sigma, 32'h0);
`endif

    // Case 4: back-pressure with a pending request; result must hold, no accept.
    bus.a0       = 32'h0;
    bus.a1       = 32'h0003_0000;
    bus.in_ch    = 2'd2;
    bus.in_valid = 1'b1;
    repeat (20) tick();
    check("bp.out_valid", bus.out_valid, 1'b1);
    check("bp.in_ready",  bus.in_ready,  1'b0);
    check("bp.kappa",     bus.kappa,     32'h0001_0000);
    check("bp.regime",    bus.regime,    3'b001);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("bp.drop_valid", bus.out_valid, 1'b0);
    check("bp.ready_back", bus.in_ready,  1'b1);
    check("bp.kappa_hold", bus.kappa,     32'h0001_0000);
    tick();
    bus.in_valid = 1'b0;
    check("bp.accepted", bus.in_ready, 1'b0);

    // Case 3: alpha=0, beta=3.0 -> overdamped, kappa=1.5, 1/kappa=floor(2^32/0x18000).
    wait_result(0, 0, n);
    check("c3.latency", n, LAT);
    check_result("c3", 3'b100, 32'h0001_8000, 32'd43690, 1'b0, 2'd2);
`ifdef EIG_SIGMA_EN
    check("c3.sigma", bus.sigma, 32'hFFFE_8000);
`endif
    accept_result("c3");

    // Case 2: alpha=1.0, beta=2.0 -> critical, divide by zero saturates.
    send(32'h0001_0000, 32'h0002_0000, 2'd3);
    wait_result(0, 0, n);
    check("c2.latency", n, LAT);
    check_result("c2", 3'b010, 32'h0, 32'h7FFF_FFFF, 1'b1, 2'd3);
    accept_result("c2");

    // Case 5: reset 30 cycles into SQRT aborts the calculation.
    send(32'h0001_0000, 32'h0, 2'd1);
    repeat (31) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_reset("abort");
    repeat (80) tick();
    check("abort.no_stale_valid", bus.out_valid, 1'b0);
    check("abort.still_idle",     bus.in_ready,  1'b1);

    // Case 6: ena low for 10 cycles mid-RECIP stretches latency by exactly 10.
    send(32'h0001_0000, 32'h0, 2'd1);
    wait_result(50, 10, n);
    check("c6.latency", n, LAT + 10);
    check_result("c6", 3'b001, 32'h0001_0000, 32'h0001_0000, 1'b0, 2'd1);

    // ena=0 blocks the output handshake.
    ena           = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    check("freeze.out_valid", bus.out_valid, 1'b1);
    ena = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("freeze.released", bus.out_valid, 1'b0);

    // ena=0 also blocks the input handshake.
    ena          = 1'b0;
    bus.in_valid = 1'b1;
    repeat (3) tick();
    bus.in_valid = 1'b0;
    ena          = 1'b1;
    tick();
    check("freeze.no_accept", bus.in_ready, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
